// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM feeding ULAControl and the datapath enables.
// Define JUMP_EN to add the J instruction (JUMP state); otherwise OPC_J decodes as illegal.
module mc_main_control #(
  parameter logic [5:0] OPC_R   = 6'b000000,
  parameter logic [5:0] OPC_LW  = 6'b100011,
  parameter logic [5:0] OPC_SW  = 6'b101011,
  parameter logic [5:0] OPC_BEQ = 6'b000100,
  parameter logic [5:0] OPC_J   = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] OpALU,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_t;

  state_t state_q, state_d;

  // Asynchronous entry to RST decodes every strobe low without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign state_dbg = state_q;

  always_comb begin
    state_d     = S_FETCH;
    OpALU       = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEM_ADDR;
        else if (opcode == OPC_R)                 state_d = S_R_EXEC;
        else if (opcode == OPC_BEQ)               state_d = S_BRANCH;
`ifdef JUMP_EN
        else if (opcode == OPC_J)                 state_d = S_JUMP;
`else
        else if (opcode == OPC_J)                 illegal_op = 1'b1;
`endif
        else                                      illegal_op = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OPC_LW)      state_d = S_MEM_READ;
        else if (opcode == OPC_SW) state_d = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        OpALU   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        OpALU       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized bench for mc_main_control against a per-instruction state-walk model.
module tb_mc_main_control;
  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_J   = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] OpALU, ALUSrcB, PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [3:0] state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .OpALU(OpALU), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

`ifdef JUMP_EN
  localparam bit JMP = 1'b1;
`else
  localparam bit JMP = 1'b0;
`endif

  function automatic bit is_legal(input logic [5:0] op);
    return op == OPC_R || op == OPC_LW || op == OPC_SW || op == OPC_BEQ || (JMP && op == OPC_J);
  endfunction

  // Packed: {OpALU,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,illegal_op}
  function automatic logic [16:0] pack_dut();
    return {OpALU, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, illegal_op};
  endfunction

  function automatic logic [16:0] exp_out(input int st, input bit rdy, input logic [5:0] op);
    logic [1:0] opalu = 2'b00, srcb = 2'b00, pcsrc = 2'b00;
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    bit m2r = 0, rdst = 0, rwr = 0, srca = 0, ill = 0;
    case (st)
      1:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      2:  begin srcb = 2'b11; ill = !is_legal(op); end
      3:  begin srca = 1; srcb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rwr = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin srca = 1; opalu = 2'b10; end
      8:  begin rwr = 1; rdst = 1; end
      9:  begin srca = 1; opalu = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      10: begin pcw = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    return {opalu, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, pcsrc, ill};
  endfunction

  // mode 0: mem_ready always high; 1: random with forced ready after 4 stalls;
  // 2: memory-phase wait holds mem_ready low for exactly 'stall' cycles.
  task automatic run_instr(input logic [5:0] op, input int mode, input int stall,
                           input string name, output int cycles);
    int st_q[$];
    bit wt_q[$];
    st_q = {1, 2};
    wt_q = {1'b1, 1'b0};
    if (op == OPC_LW)       begin st_q = {st_q, 3, 4, 5}; wt_q = {wt_q, 1'b0, 1'b1, 1'b0}; end
    else if (op == OPC_SW)  begin st_q = {st_q, 3, 6};    wt_q = {wt_q, 1'b0, 1'b1}; end
    else if (op == OPC_R)   begin st_q = {st_q, 7, 8};    wt_q = {wt_q, 1'b0, 1'b0}; end
    else if (op == OPC_BEQ) begin st_q = {st_q, 9};       wt_q = {wt_q, 1'b0}; end
    else if (JMP && op == OPC_J) begin st_q = {st_q, 10}; wt_q = {wt_q, 1'b0}; end
    cycles = 0;
    for (int k = 0; k < st_q.size(); k++) begin
      int  low = 0;
      bit  done = 0;
      bit  rdy;
      while (!done) begin
        @(negedge clk);
        if (!wt_q[k])       rdy = 1'($urandom % 2);
        else if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = (low >= 4) ? 1'b1 : ($urandom % 3 != 0);
        else                rdy = (st_q[k] == 1) ? 1'b1 : (low >= stall);
        mem_ready = rdy;
        opcode    = op;
        #1;
        chk_cnt++;
        if (state_dbg !== 4'(st_q[k]))
          $display("FAIL %s state op=%b cyc=%0d actual=%0d expected=%0d", name, op, cycles, state_dbg, st_q[k]);
        else pass_cnt++;
        chk_cnt++;
        if (pack_dut() !== exp_out(st_q[k], rdy, op))
          $display("FAIL %s outputs op=%b state=%0d actual=%h expected=%h", name, op, st_q[k], pack_dut(), exp_out(st_q[k], rdy, op));
        else pass_cnt++;
        cycles++;
        if (!wt_q[k] || rdy) done = 1;
        else low++;
      end
    end
    $display("instr %s op=%b mode=%0d cycles=%0d", name, op, mode, cycles);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    #1;
    chk_cnt++;
    if (state_dbg !== 4'd0 || pack_dut() !== 17'd0)
      $display("FAIL reset_state actual=%0d/%h expected=0/0", state_dbg, pack_dut());
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if (state_dbg !== 4'd0) $display("FAIL reset_hold actual=%0d expected=0", state_dbg);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (state_dbg !== 4'd1) $display("FAIL reset_release actual=%0d expected=1", state_dbg);
    else pass_cnt++;
    $display("reset: state after release edge=%0d", state_dbg);
  endtask

  task automatic test_async_reset();
    int n = 0;
    @(negedge clk);
    opcode = OPC_SW; mem_ready = 1'b1;
    while (state_dbg !== 4'd6 && n < 8) begin
      @(negedge clk); n++;
    end
    mem_ready = 1'b0;
    chk_cnt++;
    if (state_dbg !== 4'd6) $display("FAIL async_reach_memwrite actual=%0d expected=6", state_dbg);
    else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (state_dbg !== 4'd0 || MemWrite !== 1'b0)
      $display("FAIL async_reset actual=%0d/%b expected=0/0", state_dbg, MemWrite);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_cnt++;
    if (state_dbg !== 4'd1) $display("FAIL async_release actual=%0d expected=1", state_dbg);
    else pass_cnt++;
    $display("async reset mid MEM_WRITE: state after release=%0d", state_dbg);
  endtask

  task automatic test_cycle_counts();
    logic [5:0] ops [6];
    int         need[6];
    int         cyc;
    ops  = '{OPC_LW, OPC_SW, OPC_R, OPC_BEQ, 6'b111111, OPC_J};
    need = '{5, 4, 4, 3, 2, JMP ? 3 : 2};
    for (int i = 0; i < 6; i++) begin
      run_instr(ops[i], 0, 0, "count", cyc);
      chk_cnt++;
      if (cyc !== need[i]) $display("FAIL cycle_count op=%b actual=%0d expected=%0d", ops[i], cyc, need[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sw_stall();
    int cyc;
    run_instr(OPC_SW, 2, 3, "sw_stall", cyc);
    chk_cnt++;
    if (cyc !== 7) $display("FAIL sw_stall_cycles actual=%0d expected=7", cyc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [5:0] op;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: op = OPC_R;
        1: op = OPC_LW;
        2: op = OPC_SW;
        3: op = OPC_BEQ;
        4: op = OPC_J;
        default: op = 6'($urandom);
      endcase
      run_instr(op, 1, 0, "random", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_cycle_counts();
    test_sw_stall();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
